// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
//   Shared definitions for the external memory bus sequencer and the core
//   load logic: bus-cycle state encoding, grant encoding and helpers for
//   byte-lane selection and byte-enable generation on the 16-bit bus.
package mem_bus_pkg;

  // Bus-cycle phases: address setup, strobe (stretched by wait states),
  // completion/ack.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } bus_state_e;

  // Encoding of the last_grant register.
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  // Bit positions of the requesters in the arbiter request/grant vectors.
  localparam int REQ_IF = 0;
  localparam int REQ_D  = 1;

  // Pick the addressed byte out of a 16-bit word (hi = byte address bit 0).
  function automatic logic [7:0] byte_lane_sel(input logic [15:0] word,
                                               input logic        hi);
    logic [7:0] lane;
    if (hi) begin
      lane = word[15:8];
    end else begin
      lane = word[7:0];
    end
    return lane;
  endfunction

  // Active-low byte enables {nbhe, nble}: fetches read the whole word,
  // byte accesses enable only the lane selected by address bit 0.
  function automatic logic [1:0] byte_en_n(input logic is_fetch,
                                           input logic a0);
    logic [1:0] ben_n;
    if (is_fetch) begin
      ben_n = 2'b00;
    end else if (a0) begin
      ben_n = 2'b01;
    end else begin
      ben_n = 2'b10;
    end
    return ben_n;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
//   Two-requester round-robin arbiter for the memory bus.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     req[1:0]    requests (bit REQ_IF = fetch, bit REQ_D = data)
//     en          sample enable; last_grant only moves when en is high
//     grant[1:0]  one-hot grant, combinational from req and last_grant
//     last_grant  requester granted most recently (GRANT_IF / GRANT_D)
module mem_rr_arbiter
  import mem_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant,
  output logic       last_grant
);

  logic last_grant_q;
  logic last_grant_d;

  // Grant selection: a lone requester wins; on a tie the requester that
  // was not served last wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant_q == GRANT_IF) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // last_grant update when a grant is actually taken.
  always_comb begin
    last_grant_d = last_grant_q;
    if (en && grant[REQ_D]) begin
      last_grant_d = GRANT_D;
    end else if (en && grant[REQ_IF]) begin
      last_grant_d = GRANT_IF;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // last_grant register; resets to DATA so the first tie goes to fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GRANT_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/mem_bus_sequencer.sv
// mem_bus_sequencer
//   Arbitrates the external 16-bit memory bus between the instruction-fetch
//   port and the byte load/store port and runs one bus cycle per grant:
//   SETUP (address + nmreq), STROBE (nrd/nwr, WAIT_STATES+1 cycles),
//   DONE (one-cycle ack). All bus and ack outputs come straight from flops.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     if_req/if_addr           fetch request, byte address (bit 0 ignored)
//     if_ack/if_rdata          fetch ack pulse, fetched word
//     d_req/d_we/d_addr/d_wdata data request, store flag, address, byte
//     d_ack/d_rdata            data ack pulse, loaded byte
//     abus                     word address {1'b0, addr[15:1]}
//     dbus_o/dbus_oe/dbus_i    pad write data, output enable, read data
//     nmreq,nrd,nwr,nbhe,nble  active-low bus strobes
//     busy                     high whenever a bus cycle is in progress
module mem_bus_sequencer
  import mem_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic        d_ack,
  output logic [7:0]  d_rdata,
  output logic [15:0] abus,
  output logic [15:0] dbus_o,
  output logic        dbus_oe,
  input  logic [15:0] dbus_i,
  output logic        nmreq,
  output logic        nrd,
  output logic        nwr,
  output logic        nbhe,
  output logic        nble,
  output logic        busy
);

  localparam logic [2:0] LAST_STROBE = 3'(WAIT_STATES);

  bus_state_e  state_q, state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;

  logic [15:0] abus_q, abus_d;
  logic [15:0] dbus_o_q, dbus_o_d;
  logic        dbus_oe_q, dbus_oe_d;
  logic        nmreq_q, nmreq_d;
  logic        nrd_q, nrd_d;
  logic        nwr_q, nwr_d;
  logic        nbhe_q, nbhe_d;
  logic        nble_q, nble_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [7:0]  d_rdata_q, d_rdata_d;
  logic        busy_q, busy_d;

  logic [1:0]  grant_s;
  logic        last_grant_s;
  logic        arb_en_s;
  logic        sel_s;
  logic        capture_s;
  logic        active_s;
  logic [1:0]  ben_n_s;

  assign arb_en_s = (state_q == ST_IDLE);

  mem_rr_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        ({d_req, if_req}),
    .en         (arb_en_s),
    .grant      (grant_s),
    .last_grant (last_grant_s)
  );

  // Bus-cycle sequencing and request latching. last_grant doubles as the
  // "who owns this cycle" register, since it only moves on a grant in IDLE.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_s      = last_grant_s;
    capture_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_s[REQ_D]) begin
          state_d = ST_SETUP;
          sel_s   = GRANT_D;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
        end else if (grant_s[REQ_IF]) begin
          state_d = ST_SETUP;
          sel_s   = GRANT_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d    = ST_STROBE;
        wait_cnt_d = 3'd0;
      end
      ST_STROBE: begin
        if (wait_cnt_q == LAST_STROBE) begin
          // Read data is sampled at the edge that ends the last strobe cycle.
          state_d   = ST_DONE;
          capture_s = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the state being entered, so every bus pin is a flop.
  always_comb begin
    active_s  = (state_d != ST_IDLE);
    ben_n_s   = active_s ? byte_en_n(sel_s == GRANT_IF, addr_d[0]) : 2'b11;
    nmreq_d   = ~active_s;
    nbhe_d    = ben_n_s[1];
    nble_d    = ben_n_s[0];
    nrd_d     = ~((state_d == ST_STROBE) && !we_d);
    nwr_d     = ~((state_d == ST_STROBE) && we_d);
    abus_d    = active_s ? {1'b0, addr_d[15:1]} : abus_q;
    dbus_oe_d = active_s && we_d;
    dbus_o_d  = (active_s && we_d) ? {wdata_d, wdata_d} : dbus_o_q;
    if_ack_d  = (state_d == ST_DONE) && (sel_s == GRANT_IF);
    d_ack_d   = (state_d == ST_DONE) && (sel_s == GRANT_D);
    busy_d    = active_s;
    if (capture_s && (last_grant_s == GRANT_IF)) begin
      if_rdata_d = dbus_i;
    end else begin
      if_rdata_d = if_rdata_q;
    end
    // Stores leave the load result untouched.
    if (capture_s && (last_grant_s == GRANT_D) && !we_q) begin
      d_rdata_d = byte_lane_sel(dbus_i, addr_q[0]);
    end else begin
      d_rdata_d = d_rdata_q;
    end
  end

  // State, latched request and output registers; reset kills any bus cycle
  // in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 3'd0;
      we_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      abus_q     <= 16'h0000;
      dbus_o_q   <= 16'h0000;
      dbus_oe_q  <= 1'b0;
      nmreq_q    <= 1'b1;
      nrd_q      <= 1'b1;
      nwr_q      <= 1'b1;
      nbhe_q     <= 1'b1;
      nble_q     <= 1'b1;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= 16'h0000;
      d_rdata_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      abus_q     <= abus_d;
      dbus_o_q   <= dbus_o_d;
      dbus_oe_q  <= dbus_oe_d;
      nmreq_q    <= nmreq_d;
      nrd_q      <= nrd_d;
      nwr_q      <= nwr_d;
      nbhe_q     <= nbhe_d;
      nble_q     <= nble_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign abus     = abus_q;
  assign dbus_o   = dbus_o_q;
  assign dbus_oe  = dbus_oe_q;
  assign nmreq    = nmreq_q;
  assign nrd      = nrd_q;
  assign nwr      = nwr_q;
  assign nbhe     = nbhe_q;
  assign nble     = nble_q;
  assign if_ack   = if_ack_q;
  assign d_ack    = d_ack_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = busy_q;

endmodule
